// File: rtl/alu_issue_arbiter.sv
// Age-ordered two-port arbiter that feeds one ALU from a single-entry buffer.
// Drops uops younger than a backend redirect and counts two-requester collisions.
module alu_issue_arbiter #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ROB_IDX_W = 5,
  parameter int unsigned FUOP_W    = 7,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [XLEN-1:0]      req0_src0,
  input  logic [XLEN-1:0]      req0_src1,
  input  logic [FUOP_W-1:0]    req0_fuOpType,
  input  logic                 req0_robIdx_flag,
  input  logic [ROB_IDX_W-1:0] req0_robIdx_value,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [XLEN-1:0]      req1_src0,
  input  logic [XLEN-1:0]      req1_src1,
  input  logic [FUOP_W-1:0]    req1_fuOpType,
  input  logic                 req1_robIdx_flag,
  input  logic [ROB_IDX_W-1:0] req1_robIdx_value,
  input  logic                 redirect_valid,
  input  logic                 redirect_robIdx_flag,
  input  logic [ROB_IDX_W-1:0] redirect_robIdx_value,
  output logic                 alu_valid,
  input  logic                 alu_ready,
  output logic [XLEN-1:0]      alu_src0,
  output logic [XLEN-1:0]      alu_src1,
  output logic [FUOP_W-1:0]    alu_fuOpType,
  output logic                 alu_robIdx_flag,
  output logic [ROB_IDX_W-1:0] alu_robIdx_value,
  output logic                 alu_src_port,
  output logic [CNT_W-1:0]     conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // True when ROB entry a is younger than ROB entry b (flag toggles on wrap).
  function automatic logic is_after(input logic                 a_flag,
                                    input logic [ROB_IDX_W-1:0] a_value,
                                    input logic                 b_flag,
                                    input logic [ROB_IDX_W-1:0] b_value);
    return (a_flag ^ b_flag) ^ (a_value > b_value);
  endfunction

  logic                 r_buf_valid;
  logic [XLEN-1:0]      r_src0;
  logic [XLEN-1:0]      r_src1;
  logic [FUOP_W-1:0]    r_fuop;
  logic                 r_flag;
  logic [ROB_IDX_W-1:0] r_value;
  logic                 r_port;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_req0_younger;
  logic                 w_grant0;
  logic                 w_grant1;
  logic                 w_space;
  logic                 w_fire;
  logic [XLEN-1:0]      w_sel_src0;
  logic [XLEN-1:0]      w_sel_src1;
  logic [FUOP_W-1:0]    w_sel_fuop;
  logic                 w_sel_flag;
  logic [ROB_IDX_W-1:0] w_sel_value;
  logic                 w_kill_in;
  logic                 w_kill_buf;

  assign w_req0_younger = is_after(req0_robIdx_flag, req0_robIdx_value,
                                   req1_robIdx_flag, req1_robIdx_value);
  assign w_grant1 = req1_valid & (~req0_valid | w_req0_younger);
  assign w_grant0 = req0_valid & ~w_grant1;
  assign w_space  = ~r_buf_valid | alu_ready;

  // Ready ignores redirect: a killed arrival still handshakes and is dropped.
  assign req0_ready = w_grant0 & w_space & ~reset;
  assign req1_ready = w_grant1 & w_space & ~reset;
  assign w_fire     = req0_ready | req1_ready;

  always_comb begin
    w_sel_src0  = req0_src0;
    w_sel_src1  = req0_src1;
    w_sel_fuop  = req0_fuOpType;
    w_sel_flag  = req0_robIdx_flag;
    w_sel_value = req0_robIdx_value;
    if (w_grant1) begin
      w_sel_src0  = req1_src0;
      w_sel_src1  = req1_src1;
      w_sel_fuop  = req1_fuOpType;
      w_sel_flag  = req1_robIdx_flag;
      w_sel_value = req1_robIdx_value;
    end
  end

  assign w_kill_in  = redirect_valid & is_after(w_sel_flag, w_sel_value,
                                                redirect_robIdx_flag, redirect_robIdx_value);
  assign w_kill_buf = redirect_valid & is_after(r_flag, r_value,
                                                redirect_robIdx_flag, redirect_robIdx_value);

  // A buffered uop being flushed this cycle is hidden from the ALU immediately.
  assign alu_valid = r_buf_valid & ~w_kill_buf;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_buf_valid <= 1'b0;
      r_src0      <= '0;
      r_src1      <= '0;
      r_fuop      <= '0;
      r_flag      <= 1'b0;
      r_value     <= '0;
      r_port      <= 1'b0;
    end else if (w_fire) begin
      r_buf_valid <= ~w_kill_in;
      r_src0      <= w_sel_src0;
      r_src1      <= w_sel_src1;
      r_fuop      <= w_sel_fuop;
      r_flag      <= w_sel_flag;
      r_value     <= w_sel_value;
      r_port      <= w_grant1;
    end else if (r_buf_valid & (alu_ready | w_kill_buf)) begin
      r_buf_valid <= 1'b0;
    end
  end

  // Saturating collision counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (req0_valid & req1_valid & (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign alu_src0         = r_src0;
  assign alu_src1         = r_src1;
  assign alu_fuOpType     = r_fuop;
  assign alu_robIdx_flag  = r_flag;
  assign alu_robIdx_value = r_value;
  assign alu_src_port     = r_port;
  assign conflict_cnt     = r_cnt;

endmodule
